// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between EX/MEM and MEM/WB.
// Issues data-memory loads/stores over a req/ack bus (word or byte), resolves
// branches/jumps combinationally and registers the write-back entry.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned word accesses are not
// issued and instead retire with wb_fault=1; otherwise word addresses are
// silently aligned and wb_fault is tied low.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        in_mem_wr_rd,
  input  logic              in_word_byte,
  input  logic [31:0]       in_alu_out,
  input  logic [31:0]       in_store_data,
  input  logic              in_reg_write,
  input  logic [1:0]        in_reg_src,
  input  logic [15:0]       in_imm,
  input  logic [4:0]        in_dest,
  input  logic [1:0]        in_branch,
  input  logic [1:0]        in_jump,
  input  logic              in_zf,
  input  logic [31:0]       in_branch_addr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              pc_redirect,
  output logic [31:0]       pc_target,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_fault
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t              state_q;
  logic                dmem_req_q, dmem_we_q;
  logic [ADDR_W-1:0]   dmem_addr_q;
  logic [3:0]          dmem_be_q;
  logic [DATA_W-1:0]   dmem_wdata_q;
  logic                wb_valid_q, wb_reg_write_q;
  logic [4:0]          wb_dest_q;
  logic [DATA_W-1:0]   wb_data_q;

  logic                is_load, is_store, memop, trap, issue;
  logic [ADDR_W-1:0]   addr_d;
  logic [3:0]          be_d;
  logic [DATA_W-1:0]   wdata_d, load_data_d, wb_data_d;

  // Little-endian byte lane select with sign extension for byte loads.
  function automatic logic [DATA_W-1:0] byte_sext(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

  // Decode the op, form the bus request fields and the write-back mux.
  always_comb begin
    is_load  = (in_mem_wr_rd == 2'b01);
    is_store = (in_mem_wr_rd == 2'b10);
    memop    = is_load | is_store;
`ifdef MEM_MISALIGN_TRAP_EN
    trap     = memop & in_word_byte & (in_alu_out[1:0] != 2'b00);
`else
    trap     = 1'b0;
`endif
    issue    = in_valid & memop & ~trap;
    // Word addresses are always presented aligned; byte addresses pass through.
    addr_d   = in_word_byte ? {in_alu_out[ADDR_W-1:2], 2'b00} : in_alu_out[ADDR_W-1:0];
    be_d     = in_word_byte ? 4'hF : (4'b0001 << in_alu_out[1:0]);
    wdata_d  = in_word_byte ? in_store_data : {4{in_store_data[7:0]}};
    // EX/MEM is held during the access, so the input lane is still the access lane.
    load_data_d = in_word_byte ? dmem_rdata : byte_sext(dmem_rdata, in_alu_out[1:0]);
    case (in_reg_src)
      2'b01:   wb_data_d = load_data_d;
      2'b10:   wb_data_d = {16'b0, in_imm};
      default: wb_data_d = in_alu_out;
    endcase
  end

  assign stall       = ((state_q == S_IDLE) & issue) | ((state_q == S_WAIT) & ~dmem_ack);
  assign pc_redirect = in_valid & ((in_jump != 2'b00) |
                                   ((in_branch == 2'b01) & in_zf) |
                                   ((in_branch == 2'b10) & ~in_zf));
  assign pc_target   = in_branch_addr;

  // Access FSM: issue in IDLE, hold the request in WAIT until ack, retire to MEM/WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_be_q      <= 4'h0;
      dmem_wdata_q   <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_dest_q      <= 5'd0;
      wb_data_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            state_q        <= S_WAIT;
            dmem_req_q     <= 1'b1;
            dmem_we_q      <= is_store;
            dmem_addr_q    <= addr_d;
            dmem_be_q      <= be_d;
            dmem_wdata_q   <= wdata_d;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
          end else begin
            wb_valid_q     <= in_valid;
            wb_reg_write_q <= in_valid & in_reg_write & ~trap;
            wb_dest_q      <= in_dest;
            wb_data_q      <= wb_data_d;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state_q        <= S_IDLE;
            dmem_req_q     <= 1'b0;
            wb_valid_q     <= 1'b1;
            wb_reg_write_q <= in_valid & in_reg_write;
            wb_dest_q      <= in_dest;
            wb_data_q      <= wb_data_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic wb_fault_q;

  // Fault flag retires alongside the trapped instruction's MEM/WB entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wb_fault_q <= 1'b0;
    else if (state_q == S_IDLE)
      wb_fault_q <= in_valid & trap;
    else if (dmem_ack)
      wb_fault_q <= 1'b0;
  end

  assign wb_fault = wb_fault_q;
`else
  assign wb_fault = 1'b0;
`endif

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_be      = dmem_be_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_dest      = wb_dest_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: per-cycle comparison against a behavioural model
// plus hand-computed literal expectations for the directed vectors.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_word_byte, in_reg_write, in_zf;
  logic [1:0]  in_mem_wr_rd, in_reg_src, in_branch, in_jump;
  logic [31:0] in_alu_out, in_store_data, in_branch_addr;
  logic [15:0] in_imm;
  logic [4:0]  in_dest;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, pc_redirect, wb_valid, wb_reg_write, wb_fault;
  logic [31:0] pc_target, wb_data;
  logic [4:0]  wb_dest;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mem_wr_rd(in_mem_wr_rd),
    .in_word_byte(in_word_byte), .in_alu_out(in_alu_out), .in_store_data(in_store_data),
    .in_reg_write(in_reg_write), .in_reg_src(in_reg_src), .in_imm(in_imm),
    .in_dest(in_dest), .in_branch(in_branch), .in_jump(in_jump), .in_zf(in_zf),
    .in_branch_addr(in_branch_addr), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .wb_fault(wb_fault)
  );

  int n_chk = 0;
  int n_err = 0;
  int stall_cnt = 0;

  // Model state: what the outputs must be during the current cycle.
  logic        exp_stall = 0, exp_redirect = 0, exp_req = 0, exp_we = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_data = 0;
  logic [3:0]  exp_be = 0;
  logic        exp_wbv = 0, exp_wbrw = 0, exp_fault = 0;
  logic [4:0]  exp_dest = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic f_memop(input logic [1:0] rw);
    return (rw == 2'b01) || (rw == 2'b10);
  endfunction

  function automatic logic f_trap();
`ifdef MEM_MISALIGN_TRAP_EN
    return in_word_byte && (in_alu_out % 4 != 0) && f_memop(in_mem_wr_rd);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic f_redirect();
    return in_valid && ((in_jump != 0) || (in_branch == 1 && in_zf) || (in_branch == 2 && !in_zf));
  endfunction

  function automatic logic [31:0] f_load(input logic word, input int lane, input logic [31:0] rd);
    byte b;
    int  v;
    if (word) return rd;
    b = byte'(rd >> (8 * lane));
    v = b;
    return v;
  endfunction

  function automatic logic [31:0] f_wbdata(input logic [31:0] ld);
    case (in_reg_src)
      2'd1:    return ld;
      2'd2:    return 32'(in_imm);
      default: return in_alu_out;
    endcase
  endfunction

  // Single compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (stall === 1'b1) stall_cnt++;
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("pc_redirect", 32'(pc_redirect), 32'(exp_redirect));
    chk("pc_target", pc_target, in_branch_addr);
    chk("dmem_req", 32'(dmem_req), 32'(exp_req));
    if (exp_req) begin
      chk("dmem_we", 32'(dmem_we), 32'(exp_we));
      chk("dmem_addr", dmem_addr, exp_addr);
      chk("dmem_be", 32'(dmem_be), 32'(exp_be));
      chk("dmem_wdata", dmem_wdata, exp_wdata);
    end
    chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(exp_wbrw));
    chk("wb_fault", 32'(wb_fault), 32'(exp_fault));
    if (exp_wbv && !exp_fault) begin
      chk("wb_dest", 32'(wb_dest), 32'(exp_dest));
      chk("wb_data", wb_data, exp_data);
    end
  end

  task automatic clr();
    in_valid = 0; in_mem_wr_rd = 0; in_word_byte = 0; in_alu_out = 0;
    in_store_data = 0; in_reg_write = 0; in_reg_src = 0; in_imm = 0;
    in_dest = 0; in_branch = 0; in_jump = 0; in_zf = 0; in_branch_addr = 0;
  endtask

  // Present the current inputs as one instruction and follow it to retirement.
  // ack_wait = WAIT cycles without ack before the ack cycle.
  task automatic run(input int ack_wait, input logic [31:0] rd);
    logic mem, trp;
    logic [31:0] ld;
    trp = in_valid && f_trap();
    mem = in_valid && f_memop(in_mem_wr_rd) && !trp;
    exp_redirect = f_redirect();
    exp_stall = mem;
    exp_req = 0;
    if (!mem) begin
      ld = f_load(in_word_byte, int'(in_alu_out % 4), dmem_rdata);
      @(posedge clk); #1;
      exp_wbv = in_valid; exp_wbrw = in_valid && in_reg_write && !trp;
      exp_fault = trp; exp_dest = in_dest; exp_data = f_wbdata(ld);
    end else begin
      @(posedge clk); #1;
      exp_wbv = 0; exp_wbrw = 0; exp_fault = 0; exp_req = 1;
      exp_we = (in_mem_wr_rd == 2'b10);
      exp_addr = in_word_byte ? (in_alu_out & ~32'h3) : in_alu_out;
      exp_be = in_word_byte ? 4'hF : 4'(1 << (in_alu_out % 4));
      exp_wdata = in_word_byte ? in_store_data : in_store_data[7:0] * 32'h01010101;
      cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata; cap_we = dmem_we;
      for (int k = 0; k <= ack_wait; k++) begin
        exp_stall = (k < ack_wait);
        if (k == ack_wait) begin dmem_ack = 1; dmem_rdata = rd; end
        @(posedge clk); #1;
      end
      dmem_ack = 0; exp_req = 0;
      ld = f_load(in_word_byte, int'(in_alu_out % 4), rd);
      exp_wbv = 1; exp_wbrw = in_reg_write; exp_fault = 0;
      exp_dest = in_dest; exp_data = f_wbdata(ld);
    end
  endtask

  initial begin
    clr(); dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_dmem_be", 32'(dmem_be), 32'h0);
    rst_n = 1;

    // ALU op retires next edge, no stall
    clr(); in_valid = 1; in_reg_write = 1; in_alu_out = 32'h1234; in_dest = 5;
    stall_cnt = 0;
    run(0, 0);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_dest", 32'(wb_dest), 32'd5);
    chk("alu_stall_cnt", stall_cnt, 0);

    // Word load, ack after 3 WAIT cycles
    clr(); in_valid = 1; in_mem_wr_rd = 2'b01; in_word_byte = 1; in_alu_out = 32'h100;
    in_reg_write = 1; in_reg_src = 2'b01; in_dest = 7;
    stall_cnt = 0;
    run(3, 32'hDEADBEEF);
    chk("wload_stall_cnt", stall_cnt, 4);
    chk("wload_wb_data", wb_data, 32'hDEADBEEF);
    chk("wload_be", 32'(cap_be), 32'hF);

    // Byte load lane 3, ack in first WAIT cycle
    clr(); in_valid = 1; in_mem_wr_rd = 2'b01; in_alu_out = 32'h103;
    in_reg_write = 1; in_reg_src = 2'b01; in_dest = 9;
    run(0, 32'h80FF0000);
    chk("bload_be", 32'(cap_be), 32'b1000);
    chk("bload_wb_data", wb_data, 32'hFFFFFF80);

    // Byte load lane 1, positive byte
    clr(); in_valid = 1; in_mem_wr_rd = 2'b01; in_alu_out = 32'h21;
    in_reg_write = 1; in_reg_src = 2'b01; in_dest = 3;
    run(2, 32'h11227F44);
    chk("bload1_wb_data", wb_data, 32'h0000007F);

    // Byte store 0x5A at 0x101
    clr(); in_valid = 1; in_mem_wr_rd = 2'b10; in_alu_out = 32'h101; in_store_data = 32'h1234565A;
    run(1, 0);
    chk("bstore_be", 32'(cap_be), 32'b0010);
    chk("bstore_wdata", cap_wdata, 32'h5A5A5A5A);
    chk("bstore_we", 32'(cap_we), 32'd1);
    chk("bstore_wb_rw", 32'(wb_reg_write), 32'd0);

    // Immediate select, with a stray ack in IDLE that must be ignored
    clr(); in_valid = 1; in_reg_write = 1; in_reg_src = 2'b10; in_imm = 16'hBEEF; in_dest = 12;
    dmem_ack = 1;
    run(0, 0);
    dmem_ack = 0;
    chk("imm_wb_data", wb_data, 32'h0000BEEF);

    // Branches and jump
    clr(); in_valid = 1; in_branch = 2'b10; in_zf = 0; in_branch_addr = 32'h400;
    #1;
    chk("bne_redirect", 32'(pc_redirect), 32'd1);
    chk("bne_target", pc_target, 32'h400);
    run(0, 0);
    clr(); in_valid = 1; in_branch = 2'b01; in_zf = 0; in_branch_addr = 32'h800;
    #1;
    chk("beq_redirect", 32'(pc_redirect), 32'd0);
    run(0, 0);
    clr(); in_valid = 1; in_jump = 2'b11; in_branch_addr = 32'hC00;
    run(0, 0);
    clr(); in_valid = 0; in_jump = 2'b01;
    run(0, 0);

    // Reset during WAIT drops the request at once
    clr(); in_valid = 1; in_mem_wr_rd = 2'b01; in_word_byte = 1; in_alu_out = 32'h200;
    in_reg_write = 1; in_reg_src = 2'b01;
    exp_stall = 1; exp_redirect = 0; exp_req = 0;
    @(posedge clk); #1;
    exp_req = 1; exp_we = 0; exp_addr = 32'h200; exp_be = 4'hF; exp_wdata = 0;
    exp_wbv = 0; exp_wbrw = 0; exp_fault = 0;
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("rst_mid_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_wbv", 32'(wb_valid), 32'd0);
    clr();
    exp_req = 0; exp_stall = 0; exp_wbv = 0; exp_wbrw = 0; exp_dest = 0; exp_data = 0;
    @(posedge clk); #1;
    rst_n = 1;

    // Misaligned word load
    clr(); in_valid = 1; in_mem_wr_rd = 2'b01; in_word_byte = 1; in_alu_out = 32'h102;
    in_reg_write = 1; in_reg_src = 2'b01; in_dest = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    run(0, 0);
    chk("trap_wb_fault", 32'(wb_fault), 32'd1);
    chk("trap_wb_rw", 32'(wb_reg_write), 32'd0);
`else
    run(1, 32'hCAFEF00D);
    chk("align_addr", cap_addr, 32'h100);
    chk("align_wb_data", wb_data, 32'hCAFEF00D);
`endif

    // Word store followed directly by an ALU op
    clr(); in_valid = 1; in_mem_wr_rd = 2'b10; in_word_byte = 1; in_alu_out = 32'h40;
    in_store_data = 32'hA5A5_0F0F;
    run(0, 0);
    chk("wstore_wdata", cap_wdata, 32'hA5A50F0F);
    clr(); in_valid = 1; in_reg_write = 1; in_reg_src = 2'b11; in_alu_out = 32'h77; in_dest = 31;
    run(0, 0);
    clr();
    run(0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
